vec_mem_wb_stage: RTL and testbench

//  Parametrised vector memory stage plus MEM/WB pipeline register for the vector encryption CPU.
//  - Packs LANES ALU lane results into one wide word; lane 0 sits in the LSBs.
//  - Writes that word to an addressed on-chip data RAM, with a per-lane write mask.
//  - Performs addressed wide reads.
//  - Registers the writeback controls, ALU results and read data toward the WB stage.
//  - Stall and flush give pipeline hazard control.

---
 rtl/vec_mem_wb_stage.sv | 124 ++++++++++++
 tb/tb_vec_mem_wb_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_wb_stage.sv
// vec_mem_wb_stage
// Vector memory stage of the vector encryption CPU plus its MEM/WB register.
// The LANES ALU results form one wide word (lane 0 in the LSBs). The word can be
// written to an on-chip data RAM under a per-lane mask, and the RAM can be read.
// The RAM reads the old word when a read and a write hit the same address in the
// same cycle. The writeback controls, the ALU results and the RAM read data are
// registered toward WB. Every output comes from a flop, so no input has a
// combinational path to an output.
// Priority of the pipeline controls: rst, then flushM, then stallM.

module vec_mem_wb_stage #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_W   = 4,
  parameter int CMP_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stallM,
  input  logic                    flushM,
  input  logic                    regWriteM,
  input  logic                    memWriteM,
  input  logic                    memReadM,
  input  logic                    resultSrcM,
  input  logic [LANES-1:0]        laneEnM,
  input  logic [ADDR_W-1:0]       addrM,
  input  logic [LANES*LANE_W-1:0] aluResM,
  input  logic [RD_W-1:0]         RdM,
  input  logic [CMP_W-1:0]        resCmpM,
  output logic                    regWriteW,
  output logic                    resultSrcW,
  output logic [RD_W-1:0]         RdW,
  output logic [CMP_W-1:0]        resCompareW,
  output logic [LANES*LANE_W-1:0] aluResW,
  output logic [LANES*LANE_W-1:0] readDataW,
  output logic                    readValidW
);

  localparam int DATA_W = LANES * LANE_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // The data RAM. Each entry is a wide word split into lanes, so the lane mask
  // can act on one lane at a time. Reset does not clear the RAM.
  logic [LANES-1:0][LANE_W-1:0] mem_r [DEPTH];

  logic             issue_ok_s;  // no reset, flush or stall this cycle
  logic [LANES-1:0] lane_we_s;   // per-lane RAM write enables
  logic             rd_go_s;     // a RAM read takes place this cycle

  // The RAM is touched only in a cycle with no reset, flush or stall.
  always_comb begin
    issue_ok_s = 1'b0;
    lane_we_s  = {LANES{1'b0}};
    rd_go_s    = 1'b0;
    issue_ok_s = ~rst & ~stallM & ~flushM;
    if (issue_ok_s && memWriteM) begin
      lane_we_s = laneEnM;
    end else begin
      lane_we_s = {LANES{1'b0}};
    end
    if (issue_ok_s && memReadM) begin
      rd_go_s = 1'b1;
    end else begin
      rd_go_s = 1'b0;
    end
  end

  // Write the enabled lanes of addrM. Lanes with a clear mask bit keep their old data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we_s[i]) begin
        mem_r[addrM][i] <= aluResM[i*LANE_W +: LANE_W];
      end
    end
  end

  // Synchronous RAM read. The nonblocking write above means this read sees the
  // old word when both hit one address. The data holds when no read takes place.
  always_ff @(posedge clk) begin
    if (rst) begin
      readDataW <= {DATA_W{1'b0}};
    end else if (rd_go_s) begin
      readDataW <= mem_r[addrM];
    end else begin
      readDataW <= readDataW;
    end
  end

  // MEM/WB pipeline register.
  // Reset clears it. A flush loads a bubble. A stall holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWriteW   <= 1'b0;
      resultSrcW  <= 1'b0;
      RdW         <= {RD_W{1'b0}};
      resCompareW <= {CMP_W{1'b0}};
      aluResW     <= {DATA_W{1'b0}};
      readValidW  <= 1'b0;
    end else if (flushM) begin
      regWriteW   <= 1'b0;
      resultSrcW  <= resultSrcM;
      RdW         <= RdM;
      resCompareW <= resCmpM;
      aluResW     <= aluResM;
      readValidW  <= 1'b0;
    end else if (stallM) begin
      regWriteW   <= regWriteW;
      resultSrcW  <= resultSrcW;
      RdW         <= RdW;
      resCompareW <= resCompareW;
      aluResW     <= aluResW;
      readValidW  <= readValidW;
    end else begin
      regWriteW   <= regWriteM;
      resultSrcW  <= resultSrcM;
      RdW         <= RdM;
      resCompareW <= resCmpM;
      aluResW     <= aluResM;
      readValidW  <= memReadM;
    end
  end

endmodule

// File: tb/tb_vec_mem_wb_stage.sv
// Self-checking bench for vec_mem_wb_stage.
// The stimulus side issues one cycle at a time. For each cycle it updates a
// reference model (a plain word array plus the expected W-register contents)
// and pushes the expected outputs into a queue. A separate monitor pops one
// entry for each registered cycle and compares it with the DUT outputs.

module tb_vec_mem_wb_stage;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 8;
  localparam int RD_W   = 4;
  localparam int CMP_W  = 4;
  localparam int DATA_W = LANES * LANE_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, stallM, flushM, regWriteM, memWriteM, memReadM, resultSrcM;
  logic [LANES-1:0]  laneEnM;
  logic [ADDR_W-1:0] addrM;
  logic [DATA_W-1:0] aluResM;
  logic [RD_W-1:0]   RdM;
  logic [CMP_W-1:0]  resCmpM;
  logic              regWriteW, resultSrcW, readValidW;
  logic [RD_W-1:0]   RdW;
  logic [CMP_W-1:0]  resCompareW;
  logic [DATA_W-1:0] aluResW, readDataW;

  vec_mem_wb_stage #(
    .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .CMP_W(CMP_W)
  ) dut (
    .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .memReadM(memReadM),
    .resultSrcM(resultSrcM), .laneEnM(laneEnM), .addrM(addrM),
    .aluResM(aluResM), .RdM(RdM), .resCmpM(resCmpM),
    .regWriteW(regWriteW), .resultSrcW(resultSrcW), .RdW(RdW),
    .resCompareW(resCompareW), .aluResW(aluResW), .readDataW(readDataW),
    .readValidW(readValidW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rw;
    logic              rs;
    logic [RD_W-1:0]   rd;
    logic [CMP_W-1:0]  cmp;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data;
    logic              valid;
    bit                chk_ctl;
    bit                chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the RAM as an array of lane words, plus the expected W register.
  logic [LANE_W-1:0] mem [DEPTH][LANES];
  exp_t              m;

  task automatic issue(input logic r, input logic s, input logic f,
                       input logic rw, input logic mw, input logic mr, input logic rs,
                       input logic [LANES-1:0] en, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] alu, input logic [RD_W-1:0] rd,
                       input logic [CMP_W-1:0] cmp);
    rst = r; stallM = s; flushM = f; regWriteM = rw; memWriteM = mw; memReadM = mr;
    resultSrcM = rs; laneEnM = en; addrM = a; aluResM = alu; RdM = rd; resCmpM = cmp;
    if (r) begin
      m.rw = 1'b0; m.rs = 1'b0; m.rd = '0; m.cmp = '0; m.alu = '0;
      m.data = '0; m.valid = 1'b0; m.chk_ctl = 1'b1; m.chk_data = 1'b1;
    end else if (f) begin
      m.rw = 1'b0; m.valid = 1'b0; m.chk_ctl = 1'b0; m.chk_data = 1'b0;
    end else if (!s) begin
      m.rw = rw; m.rs = rs; m.rd = rd; m.cmp = cmp; m.alu = alu; m.chk_ctl = 1'b1;
      m.valid = mr;
      if (mr) begin
        for (int i = 0; i < LANES; i++) m.data[i*LANE_W +: LANE_W] = mem[a][i];
        m.chk_data = 1'b1;
      end
      if (mw) begin
        for (int i = 0; i < LANES; i++)
          if (en[i]) mem[a][i] = alu[i*LANE_W +: LANE_W];
      end
    end
    @(posedge clk);
    exp_q.push_back(m);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] en,
                    input logic [DATA_W-1:0] d);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, en, a, d, 4'h1, 4'h0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, a, 128'h0, 4'h2, 4'h5);
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one expected entry per registered cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regWriteW", {127'b0, regWriteW}, {127'b0, e.rw});
        chk("readValidW", {127'b0, readValidW}, {127'b0, e.valid});
        if (e.chk_ctl) begin
          chk("resultSrcW", {127'b0, resultSrcW}, {127'b0, e.rs});
          chk("RdW", {124'b0, RdW}, {124'b0, e.rd});
          chk("resCompareW", {124'b0, resCompareW}, {124'b0, e.cmp});
          chk("aluResW", aluResW, e.alu);
        end
        if (e.chk_data) chk("readDataW", readDataW, e.data);
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] rnd;
    int                cnt;
    m = '{rw: 1'b0, rs: 1'b0, rd: '0, cmp: '0, alu: '0, data: '0, valid: 1'b0,
          chk_ctl: 1'b0, chk_data: 1'b0};
    // Reset for two cycles, with non-zero inputs present.
    repeat (2) issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 8'd3,
                     128'hFFFF, 4'hF, 4'hF);
    // Fill every RAM word so that every later read has a defined value.
    for (int a = 0; a < DEPTH; a++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      wr(a[ADDR_W-1:0], 4'hF, rnd);
    end
    // Full write, then read back.
    wr(8'd5, 4'hF, 128'h0000_4444_0000_3333_0000_2222_0000_1111);
    rd(8'd5);
    // Partial write of lane 2 only, then read back.
    wr(8'd5, 4'b0100, {32'h0, 32'hAAAA_AAAA, 32'h0, 32'h0});
    rd(8'd5);
    // Same-cycle read and write on one address returns the old word. A read in the next cycle returns the new word.
    wr(8'd9, 4'hF, 128'h0);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'd9,
          {4{32'h0000_BEEF}}, 4'h3, 4'h0);
    rd(8'd9);
    // Three stalled cycles with a write request. Then a release with RdM=7.
    repeat (3) issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'd9,
                     {4{32'hDEAD_0000}}, 4'h7, 4'h9);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd9, 128'h5, 4'h7, 4'h9);
    rd(8'd9);
    // Flush together with stall, regWrite and memWrite. Then read back.
    issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 8'd9,
          {4{32'hCAFE_CAFE}}, 4'h4, 4'h1);
    rd(8'd9);
    // Randomized traffic with occasional stall, flush and reset.
    for (int k = 0; k < 600; k++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      issue(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom), 8'($urandom_range(0, 15)), rnd,
            4'($urandom), 4'($urandom));
    end
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 128'h0, 4'h0, 4'h0);
    // Drain the scoreboard, with a cycle bound.
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 10) begin
      @(posedge clk);
      cnt++;
    end
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
